// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state encoding and geometry for the icache slice
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    localparam int INDEX_BITS_DEF = 7;
    localparam int TAG_W          = 30 - INDEX_BITS_DEF;

    function automatic int tag_w(input int index_bits);
        return 30 - index_bits;
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage with async read and one sync write port
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INDEX_BITS-1:0]          rd_idx,
    output logic                           rd_valid,
    output logic [tag_w(INDEX_BITS)-1:0]   rd_tag,
    output logic [31:0]                    rd_data,
    input  logic                           wr_en,
    input  logic [INDEX_BITS-1:0]          wr_idx,
    input  logic [tag_w(INDEX_BITS)-1:0]   wr_tag,
    input  logic [31:0]                    wr_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TW    = tag_w(INDEX_BITS);

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // valid bits clear on reset and are set by fills; a reset edge wins over a fill
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // tag/data payload needs no reset since valid guards every read
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-line instruction cache; caching enabled by ICACHE_EN
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ok_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        mem_fe_o,
    output logic [31:0] mem_fpc_o,
    input  logic [31:0] mem_inst_i,
    input  logic        mem_inst_ok_i,
    input  logic [31:0] mem_inst_pc_i
);

    state_t      state_q, state_d;
    logic        ok_d, fe_d;
    logic [31:0] inst_d, pc_d, fpc_d;
    logic        hit, fill_en, resp_match;
    logic [31:0] hit_data;

    // only a return for the address currently being fetched counts
    assign resp_match = mem_inst_ok_i && (mem_inst_pc_i == mem_fpc_o);

`ifdef ICACHE_EN
    localparam int TW = tag_w(INDEX_BITS);

    logic          rd_valid;
    logic [TW-1:0] rd_tag;

    icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (if_pc_i[INDEX_BITS+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (hit_data),
        .wr_en   (fill_en && rdy),
        .wr_idx  (mem_inst_pc_i[INDEX_BITS+1:2]),
        .wr_tag  (mem_inst_pc_i[31:INDEX_BITS+2]),
        .wr_data (mem_inst_i)
    );

    assign hit = rd_valid && (rd_tag == if_pc_i[31:INDEX_BITS+2]);
`else
    logic unused_cfg;

    assign hit        = 1'b0;
    assign hit_data   = '0;
    assign unused_cfg = ^{fill_en, INDEX_BITS[0]};
`endif

    // next-state and registered-output values for the lookup/miss handshake
    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        inst_d  = if_inst_o;
        pc_d    = if_pc_o;
        fe_d    = mem_fe_o;
        fpc_d   = mem_fpc_o;
        fill_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i) begin
                    if (hit) begin
                        ok_d   = 1'b1;
                        inst_d = hit_data;
                        pc_d   = if_pc_i;
                    end else begin
                        fe_d    = 1'b1;
                        fpc_d   = if_pc_i;
                        state_d = MISS;
                    end
                end
            end
            MISS: begin
                if (resp_match) begin
                    fill_en = 1'b1;
                    fe_d    = 1'b0;
                    state_d = IDLE;
                    if (if_req_i && (if_pc_i == mem_fpc_o)) begin
                        ok_d   = 1'b1;
                        inst_d = mem_inst_i;
                        pc_d   = if_pc_i;
                    end
                end else if (!if_req_i) begin
                    fe_d    = 1'b0;
                    state_d = IDLE;
                end else if (if_pc_i != mem_fpc_o) begin
                    fpc_d = if_pc_i;
                end
            end
            default: begin
                state_d = IDLE;
                fe_d    = 1'b0;
            end
        endcase
    end

    // state and outputs: reset clears, rdy low freezes everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            if_ok_o   <= 1'b0;
            if_inst_o <= '0;
            if_pc_o   <= '0;
            mem_fe_o  <= 1'b0;
            mem_fpc_o <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            if_ok_o   <= ok_d;
            if_inst_o <= inst_d;
            if_pc_o   <= pc_d;
            mem_fe_o  <= fe_d;
            mem_fpc_o <= fpc_d;
        end
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's instruction-fetch port. IF presents a PC; hits return the instruction one cycle later; misses drive `mem_fe_o`/`mem_fpc_o` until the controller's `inst_ok` pulse, then fill the line and answer IF. PC redirects during a miss retarget the outstanding fetch, since the controller restarts on a changed fetch PC.

## Interface
- `INDEX_BITS`, default 7: log2 of line count (128 lines); index = `pc[INDEX_BITS+1:2]`, tag = `pc[31:INDEX_BITS+2]`.
- `clk`  in  1  clock, all logic on posedge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low (`rst==0` at a posedge resets).
- `rdy`  in  1  global enable; low freezes every register, including valid bits, state and outputs.
- `if_req_i`  in  1  IF requests the instruction at `if_pc_i`.
- `if_pc_i`  in  32  fetch PC, word-aligned; bits [1:0] ignored.
- `if_ok_o`  out  1  one-cycle pulse: `if_inst_o`/`if_pc_o` valid.
- `if_inst_o`  out  32  instruction word.
- `if_pc_o`  out  32  PC that `if_inst_o` belongs to.
- `mem_fe_o`  out  1  fetch request to memory controller, held until answered.
- `mem_fpc_o`  out  32  fetch address to memory controller.
- `mem_inst_i`  in  32  instruction from controller.
- `mem_inst_ok_i`  in  1  controller's one-cycle fetch-done pulse.
- `mem_inst_pc_i`  in  32  address the returned word belongs to.

## Operation
- Reset values: `if_ok_o`=0, `if_inst_o`=0, `if_pc_o`=0, `mem_fe_o`=0, `mem_fpc_o`=0, all valid bits 0, state IDLE.
- IDLE, `if_req_i`=0: stay IDLE; `if_ok_o`=0.
- IDLE, `if_req_i`=1, hit (valid[idx] && tag match): `if_ok_o`=1, `if_inst_o`=data[idx], `if_pc_o`=`if_pc_i`; stay IDLE.
- IDLE, `if_req_i`=1, miss: `mem_fe_o`=1, `mem_fpc_o`=`if_pc_i`; go MISS.
- MISS, `mem_inst_ok_i`=1 and `mem_inst_pc_i`==`mem_fpc_o`: write data/tag, set valid[idx] of `mem_inst_pc_i`. Then:
  - If `if_req_i`=1 and `if_pc_i`==`mem_fpc_o`: `if_ok_o`=1 with that word/PC, `mem_fe_o`=0, go IDLE.
  - Otherwise, no `if_ok_o`; go IDLE. A new PC is looked up next cycle.
- MISS, `if_req_i`=1, `if_pc_i`!=`mem_fpc_o`, no matching response: `mem_fpc_o`=`if_pc_i` (redirect), stay MISS, `mem_fe_o` held 1.
- MISS, `if_req_i`=0: `mem_fe_o`=0, go IDLE. A later stale `mem_inst_ok_i` is ignored.
- `mem_inst_ok_i` with `mem_inst_pc_i`!=`mem_fpc_o`, or arriving in IDLE: ignored, no array write.
- IF must change PC or drop `if_req_i` in the cycle it sees `if_ok_o`. Otherwise the same PC is looked up again (hit, duplicate pulse, harmless).
- No self-modifying-code coherence: stores never invalidate lines.

## Timing
- Hit: request sampled at edge N, `if_ok_o` high during cycle N+1, exactly one cycle.
- Miss: `mem_fe_o` rises after edge N. `if_ok_o` high in the cycle after the edge that samples `mem_inst_ok_i`.
- Miss latency is controller fetch latency + 2 cycles. The controller may delay the fetch behind data accesses; `mem_fe_o` simply stays high.
- A redirect updates `mem_fpc_o` on the next edge.
- `rdy`=0 for k cycles stretches every latency by k. A `mem_inst_ok_i` pulse coinciding with `rdy`=0 is not sampled; the controller is frozen by the same `rdy`.
- Reset mid-miss: state returns to IDLE and `mem_fe_o` goes to 0 on that edge; no line is written.

## Configuration
- `ICACHE_EN` defined: caching as above.
- `ICACHE_EN` undefined: the array is not instantiated and every lookup is treated as a miss. Fills are skipped; the handshake and the MISS/redirect behaviour are unchanged, so `if_ok_o` follows every memory return.

## Structure
- Shared package: state encoding (IDLE, MISS), `INDEX_BITS` default, derived `TAG_W` = 30-`INDEX_BITS`.
- Sub-module `icache_array`: valid/tag/data storage.
  - Combinational read port indexed by `if_pc_i`.
  - One synchronous write port.
  - Synchronous clear of all valid bits on reset.

## Test plan
- Cold fetch of 0x0000 with the controller returning 0x00000013 after 5 cycles -> `mem_fpc_o`=0x0000, then `if_ok_o` with `if_inst_o`=0x00000013, `if_pc_o`=0x0000. A repeat request hits in 1 cycle with `mem_fe_o` staying 0.
- Sequential 0x0,0x4,0x8 then loop back to 0x0 -> 3 misses, then a hit. 0x0 and 0x200 (same index, INDEX_BITS=7) alternate -> every access misses.
- Redirect: miss on 0x100, and after 2 cycles `if_pc_i`=0x400 -> `mem_fpc_o`=0x400 next cycle. A response for 0x100 arriving late is ignored, and only 0x400's data reaches IF.
- Response for 0x100 in the same cycle IF switches to 0x400 -> line 0x100 is filled, no `if_ok_o`, and the next cycle starts a miss on 0x400.
- `rdy`=0 for 3 cycles during a hit -> `if_ok_o` pulse delayed 3 cycles. Reset asserted mid-miss -> `mem_fe_o`=0 and a subsequent request to the same PC misses.
- `ICACHE_EN` undefined: two fetches of 0x0 -> two memory requests, both answered correctly.
